alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, the command-present flag.
REQ-005 SHALL have port in_ready, output, 1, the command-accept flag.
REQ-006 SHALL have port aluop, input, 2, the main-decoder op class.
REQ-007 SHALL have port funct, input, 6, the R-type function field.
REQ-008 SHALL have port shamt, input, 5, the R-type shift amount.
REQ-009 SHALL have ports rs_val, rt_val and imm_ext, input, 32 each, the register operands and sign-extended immediate.
REQ-010 SHALL have port alusrc, input, 1: 1 selects imm_ext as operand 2.
REQ-011 SHALL have ports alu_in1 and alu_in2, output, 32 each, driven to the ALU.
REQ-012 SHALL have port alu_cntrl, output, 4, driven to the ALU.
REQ-013 SHALL have port alu_dout, input, 32, the combinational ALU result.
REQ-014 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 32) and out_illegal (output, 1), the result handshake.

Function
REQ-015 SHALL decode alu_cntrl by aluop: 00 -> 0010 ADD; 01 -> 0110 SUB; 11 -> 0001 OR; 10 -> by funct.
REQ-016 SHALL, for aluop 10, decode funct: 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001; 100110 -> 0011; 100111 -> 1100; 101010 -> 0111; 000000 -> 1000; 000010 -> 1001; 000011 -> 1010.
REQ-017 SHALL select operands: non-shift ops give in1=rs_val and in2 = alusrc ? imm_ext : rt_val; fixed shifts (000000/000010/000011) give in1=rt_val and in2={27'b0,shamt}.
REQ-018 SHALL flag any other funct under aluop 10 as illegal.
REQ-019 SHALL implement FSM IDLE, EXEC, RESP; in_ready=1 only in IDLE.
REQ-020 SHALL, in IDLE with in_valid=1, register the decoded alu_cntrl, operands and illegal flag, and go to EXEC.
REQ-021 SHALL, in EXEC, drive alu_in1/alu_in2/alu_cntrl from those registers, capture alu_dout (0 if illegal) into out_data, and go to RESP.
REQ-022 SHALL, in RESP, hold out_valid=1 with out_data/out_illegal stable until out_ready=1, then go to IDLE.
REQ-023 SHALL give a latency of out_valid rising 2 cycles after the accept edge; throughput is 1 op per 3 cycles with out_ready held at 1.
REQ-024 SHALL keep alu_in1/alu_in2/alu_cntrl at their registered values in IDLE and RESP.
REQ-025 SHALL ignore in_valid outside IDLE; a command is accepted no earlier than the cycle after the RESP-to-IDLE edge.

Reset
REQ-026 SHALL, on rising edge with rst_n=0, enter IDLE and clear out_valid, out_illegal, out_data, alu_in1, alu_in2 and alu_cntrl to 0, from any state.
REQ-027 SHALL discard any in-flight command on reset mid-EXEC/RESP; no out_valid for it after reset.

Configuration
REQ-028 SHALL, with macro ALU_ISSUE_SHIFTV_EN defined, decode variable shifts 000100 -> 1000, 000110 -> 1001 and 000111 -> 1010, with in1=rt_val and in2=rs_val (ALU uses low 5 bits).
REQ-029 SHALL, without ALU_ISSUE_SHIFTV_EN, treat funct 000100/000110/000111 as illegal.

Structure
REQ-030 SHALL place ALU control codes (ALU_ADD=0010 ... ALU_SRA=1010), aluop encodings, funct constants and the FSM state enum in shared package mips_alu_pkg.
REQ-031 SHALL implement the combinational decode of REQ-015..018/028 as sub-module alu_op_decode, instantiated once.

Verification
REQ-032 SHALL cover this scenario: aluop=10, funct=100000, rs=5, rt=7, out_ready=1 -> alu_cntrl=0010, out_data=12, out_valid exactly 2 cycles after accept, out_illegal=0.
REQ-033 SHALL cover this scenario: aluop=10, funct=000000, shamt=4, rt=0x1 -> alu_in1=1, alu_in2=4, alu_cntrl=1000, out_data=0x10.
REQ-034 SHALL cover this scenario: aluop=00, alusrc=1, rs=0x100, imm=0xFFFFFFFC -> alu_cntrl=0010, out_data=0xFC.
REQ-035 SHALL cover this scenario: aluop=10, funct=111111 -> out_illegal=1, out_data=0; same with funct=000100 and no macro -> illegal; with macro, rs=3, rt=1 -> out_data=8.
REQ-036 SHALL cover this scenario: out_ready=0 for 5 cycles in RESP -> out_valid and out_data held, in_ready=0, a new in_valid ignored; with out_ready=1 -> IDLE next cycle.
REQ-037 SHALL cover this scenario: rst_n=0 one cycle during EXEC -> next cycle IDLE, in_ready=1, all outputs 0, no stale out_valid.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: ALU control codes, aluop/funct encodings and issue FSM states
package mips_alu_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;
    localparam logic [1:0] AOP_OR    = 2'b11;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational ALU control, operand select and illegal-funct flag.
// Variable shifts (sllv/srlv/srav) are decoded only when ALU_ISSUE_SHIFTV_EN is defined.
module alu_op_decode
    import mips_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        aluop,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [DATA_W-1:0] imm_ext,
    input  logic              alusrc,
    output logic [3:0]        cntrl,
    output logic [DATA_W-1:0] in1,
    output logic [DATA_W-1:0] in2,
    output logic              illegal
);
    logic shift_fixed;
    logic shift_var;

    always_comb begin
        cntrl       = ALU_ADD;
        illegal     = 1'b0;
        shift_fixed = 1'b0;
        shift_var   = 1'b0;
        case (aluop)
            AOP_ADD: cntrl = ALU_ADD;
            AOP_SUB: cntrl = ALU_SUB;
            AOP_OR:  cntrl = ALU_OR;
            default: begin
                case (funct)
                    F_ADD: cntrl = ALU_ADD;
                    F_SUB: cntrl = ALU_SUB;
                    F_AND: cntrl = ALU_AND;
                    F_OR:  cntrl = ALU_OR;
                    F_XOR: cntrl = ALU_XOR;
                    F_NOR: cntrl = ALU_NOR;
                    F_SLT: cntrl = ALU_SLT;
                    F_SLL: begin cntrl = ALU_SLL; shift_fixed = 1'b1; end
                    F_SRL: begin cntrl = ALU_SRL; shift_fixed = 1'b1; end
                    F_SRA: begin cntrl = ALU_SRA; shift_fixed = 1'b1; end
`ifdef ALU_ISSUE_SHIFTV_EN
                    F_SLLV: begin cntrl = ALU_SLL; shift_var = 1'b1; end
                    F_SRLV: begin cntrl = ALU_SRL; shift_var = 1'b1; end
                    F_SRAV: begin cntrl = ALU_SRA; shift_var = 1'b1; end
`endif
                    default: begin cntrl = ALU_AND; illegal = 1'b1; end
                endcase
            end
        endcase
    end

    // Shifts operate on rt; the amount comes from shamt or rs (ALU uses its low 5 bits)
    assign in1 = (shift_fixed || shift_var) ? rt_val : rs_val;
    assign in2 = shift_fixed ? {{(DATA_W-5){1'b0}}, shamt} :
                 shift_var   ? rs_val :
                 alusrc      ? imm_ext : rt_val;
endmodule

// File: rtl/alu_issue.sv
// alu_issue: registers a decoded ALU command, drives an external ALU for one cycle
// and returns its result over a valid/ready handshake. Option: ALU_ISSUE_SHIFTV_EN.
module alu_issue
    import mips_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        aluop,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [DATA_W-1:0] imm_ext,
    input  logic              alusrc,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [3:0]        alu_cntrl,
    input  logic [DATA_W-1:0] alu_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_illegal
);
    state_t            state, state_nx;
    logic [3:0]        dec_cntrl;
    logic [DATA_W-1:0] dec_in1, dec_in2;
    logic              dec_ill, ill_r;

    alu_op_decode #(.DATA_W(DATA_W)) u_dec (
        .aluop   (aluop),
        .funct   (funct),
        .shamt   (shamt),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .imm_ext (imm_ext),
        .alusrc  (alusrc),
        .cntrl   (dec_cntrl),
        .in1     (dec_in1),
        .in2     (dec_in2),
        .illegal (dec_ill)
    );

    always_ff @(posedge clk)
        state <= !rst_n ? S_IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = in_valid ? S_EXEC : S_IDLE;
            S_EXEC:  state_nx = S_RESP;
            S_RESP:  state_nx = out_ready ? S_IDLE : S_RESP;
            default: state_nx = S_IDLE;
        endcase
    end

    assign in_ready  = state == S_IDLE;
    assign out_valid = state == S_RESP;

    // ALU drive registers only change on accept, so they hold through EXEC and RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_cntrl   <= '0;
            ill_r       <= 1'b0;
            out_data    <= '0;
            out_illegal <= 1'b0;
        end else if (state == S_IDLE && in_valid) begin
            alu_in1   <= dec_in1;
            alu_in2   <= dec_in2;
            alu_cntrl <= dec_cntrl;
            ill_r     <= dec_ill;
        end else if (state == S_EXEC) begin
            out_data    <= ill_r ? '0 : alu_dout;
            out_illegal <= ill_r;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized scoreboard bench for alu_issue with a behavioural ALU
// and an instruction-level reference model; honours ALU_ISSUE_SHIFTV_EN.
module tb_alu_issue;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, alusrc = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, out_illegal;
    logic [1:0]  aluop = '0;
    logic [5:0]  funct = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] rs_val = '0, rt_val = '0, imm_ext = '0;
    logic [31:0] alu_in1, alu_in2, alu_dout, out_data;
    logic [3:0]  alu_cntrl;

    typedef struct {
        logic [31:0] data;
        logic        ill;
        logic [3:0]  cntrl;
        logic [31:0] in1;
        logic [31:0] in2;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0, fails = 0, cyc = 0;
    int   rdy_mode = 1;
    logic [5:0] fl [13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

    alu_issue #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct(funct), .shamt(shamt), .rs_val(rs_val), .rt_val(rt_val),
        .imm_ext(imm_ext), .alusrc(alusrc), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_cntrl(alu_cntrl), .alu_dout(alu_dout), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU the block drives
    always_comb begin
        case (alu_cntrl)
            4'b0000: alu_dout = alu_in1 & alu_in2;
            4'b0001: alu_dout = alu_in1 | alu_in2;
            4'b0010: alu_dout = alu_in1 + alu_in2;
            4'b0011: alu_dout = alu_in1 ^ alu_in2;
            4'b0110: alu_dout = alu_in1 - alu_in2;
            4'b0111: alu_dout = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
            4'b1000: alu_dout = alu_in1 << alu_in2[4:0];
            4'b1001: alu_dout = alu_in1 >> alu_in2[4:0];
            4'b1010: alu_dout = 32'($signed(alu_in1) >>> alu_in2[4:0]);
            4'b1100: alu_dout = ~(alu_in1 | alu_in2);
            default: alu_dout = 32'hDEAD_BEEF;
        endcase
    end

    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [31:0] imm, input logic src);
        exp_t e;
        logic [31:0] b;
        b = src ? imm : rt;
        e.data = '0; e.ill = 1'b0; e.cntrl = '0; e.in1 = rs; e.in2 = b; e.acc = 0;
        if (op == 2'b00) begin e.cntrl = 4'b0010; e.data = rs + b; end
        else if (op == 2'b01) begin e.cntrl = 4'b0110; e.data = rs - b; end
        else if (op == 2'b11) begin e.cntrl = 4'b0001; e.data = rs | b; end
        else begin
            case (f)
                6'h20: begin e.cntrl = 4'b0010; e.data = rs + b; end
                6'h22: begin e.cntrl = 4'b0110; e.data = rs - b; end
                6'h24: begin e.cntrl = 4'b0000; e.data = rs & b; end
                6'h25: begin e.cntrl = 4'b0001; e.data = rs | b; end
                6'h26: begin e.cntrl = 4'b0011; e.data = rs ^ b; end
                6'h27: begin e.cntrl = 4'b1100; e.data = ~(rs | b); end
                6'h2a: begin e.cntrl = 4'b0111; e.data = ($signed(rs) < $signed(b)) ? 32'd1 : 32'd0; end
                6'h00: begin e.cntrl = 4'b1000; e.in1 = rt; e.in2 = {27'b0, sh}; e.data = rt << sh; end
                6'h02: begin e.cntrl = 4'b1001; e.in1 = rt; e.in2 = {27'b0, sh}; e.data = rt >> sh; end
                6'h03: begin e.cntrl = 4'b1010; e.in1 = rt; e.in2 = {27'b0, sh}; e.data = 32'($signed(rt) >>> sh); end
`ifdef ALU_ISSUE_SHIFTV_EN
                6'h04: begin e.cntrl = 4'b1000; e.in1 = rt; e.in2 = rs; e.data = rt << rs[4:0]; end
                6'h06: begin e.cntrl = 4'b1001; e.in1 = rt; e.in2 = rs; e.data = rt >> rs[4:0]; end
                6'h07: begin e.cntrl = 4'b1010; e.in1 = rt; e.in2 = rs; e.data = 32'($signed(rt) >>> rs[4:0]); end
`endif
                default: e.ill = 1'b1;
            endcase
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic src);
        exp_t e;
        int n = 0;
        @(posedge clk); #1;
        aluop = op; funct = f; shamt = sh; rs_val = rs; rt_val = rt; imm_ext = imm; alusrc = src;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; fails++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        end else begin
            e = model(op, f, sh, rs, rt, imm, src);
            e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_illegal"}, 32'(out_illegal), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_alu_in1"}, alu_in1, 32'd0);
        chk({tag, "_alu_in2"}, alu_in2, 32'd0);
        chk({tag, "_alu_cntrl"}, 32'(alu_cntrl), 32'd0);
    endtask

    // out_ready driver: 0 = low, 1 = high, 2 = random
    initial forever begin
        @(posedge clk); #1;
        out_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    end

    // Monitor: pops the scoreboard on each completed handshake
    initial begin
        bit          prev_v = 1'b0, idle_next = 1'b0;
        logic [31:0] hd = '0;
        logic        hi = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0; idle_next = 1'b0;
                continue;
            end
            if (idle_next) chk("in_ready_after_resp", 32'(in_ready), 32'd1);
            idle_next = 1'b0;
            if (out_valid) begin
                if (!prev_v) begin
                    hd = out_data; hi = out_illegal;
                    if (q.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL unexpected_out_valid: got out_data %h, expected no response", out_data);
                    end else chk("latency_cycle", 32'(cyc), 32'(q[0].acc + 2));
                end else begin
                    chk("hold_out_data", out_data, hd);
                    chk("hold_out_illegal", 32'(out_illegal), 32'(hi));
                end
                if (out_ready && q.size() > 0) begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_illegal", 32'(out_illegal), 32'(e.ill));
                    if (!e.ill) begin
                        chk("alu_cntrl", 32'(alu_cntrl), 32'(e.cntrl));
                        chk("alu_in1", alu_in1, e.in1);
                        chk("alu_in2", alu_in2, e.in2);
                    end
                    idle_next = 1'b1;
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        int n;
        logic [5:0] f;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_cleared("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(2'b10, 6'h20, 5'd0, 32'd5, 32'd7, 32'd0, 1'b0);
        issue(2'b10, 6'h00, 5'd4, 32'd0, 32'h1, 32'd0, 1'b0);
        issue(2'b00, 6'h3f, 5'd0, 32'h100, 32'd0, 32'hFFFF_FFFC, 1'b1);
        issue(2'b10, 6'h3f, 5'd0, 32'h55, 32'h66, 32'd0, 1'b0);
        issue(2'b10, 6'h04, 5'd0, 32'd3, 32'd1, 32'd0, 1'b0);
        issue(2'b01, 6'h00, 5'd0, 32'd10, 32'd3, 32'd0, 1'b0);
        issue(2'b11, 6'h00, 5'd0, 32'hF0, 32'd0, 32'h0F, 1'b1);
        issue(2'b10, 6'h2a, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        issue(2'b10, 6'h03, 5'd31, 32'd0, 32'h8000_0000, 32'd0, 1'b0);
        issue(2'b10, 6'h27, 5'd0, 32'h0F0F_0000, 32'h0000_F0F0, 32'd0, 1'b0);
        drain();

        // Backpressure: hold RESP for 5 cycles while a new command is offered
        rdy_mode = 0;
        issue(2'b10, 6'h25, 5'd0, 32'hF0, 32'h0F, 32'd0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("resp_reached", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            in_valid = 1'b1; aluop = 2'b00; rs_val = $urandom;
            @(negedge clk);
            chk("in_ready_in_resp", 32'(in_ready), 32'd0);
            chk("out_valid_held", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rdy_mode = 1;
        drain();

        // Reset while in EXEC discards the command
        issue(2'b10, 6'h20, 5'd0, 32'h1234, 32'h1, 32'd0, 1'b0);
        rst_n = 1'b0;
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_cleared("mid_reset");
        repeat (6) @(negedge clk);

        rdy_mode = 2;
        repeat (150) begin
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 12)];
            issue(2'($urandom), f, 5'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
        end
        rdy_mode = 1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
